// File: rtl/riscv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder:
// beat class encoding, base opcodes, canonical NOP and the raw-field bundle.
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_ILL6   = 3'd6,
        CLS_ILL7   = 3'd7
    } instr_class_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef struct packed {
        instr_class_e cls;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [2:0]   funct3;
        logic         funct7b5;
        logic [31:0]  imm;
    } instr_fields_t;

    // True when v is representable as a w-bit two's-complement value.
    function automatic logic fits_simm(input logic [31:0] v, input int unsigned w);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = w; i < 32; i++) begin
            if (v[i] != v[w-1]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer: class + raw fields -> 32-bit RV32I word and error flag.
// Immediate range checking is compiled in with ENC_RANGE_CHECK_EN.
module instr_field_pack
    import riscv_enc_pkg::*;
(
    input  instr_fields_t fields,
    output logic [31:0]   word,
    output logic          enc_err
);

    logic [31:0] imm;
    logic        illegal;
    logic        range_bad;

    assign imm = fields.imm;

    always_comb begin
        word    = NOP_WORD;
        illegal = 1'b0;
        case (fields.cls)
            CLS_R:      word = {1'b0, fields.funct7b5, 5'b0, fields.rs2, fields.rs1,
                                fields.funct3, fields.rd, OPC_R};
            CLS_I:      word = {imm[11:0], fields.rs1, fields.funct3, fields.rd, OPC_I};
            CLS_LOAD:   word = {imm[11:0], fields.rs1, fields.funct3, fields.rd, OPC_LOAD};
            CLS_STORE:  word = {imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                                imm[4:0], OPC_STORE};
            CLS_BRANCH: word = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                                imm[4:1], imm[11], OPC_BRANCH};
            CLS_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, OPC_JAL};
            default:    illegal = 1'b1;
        endcase
    end

    always_comb begin
        range_bad = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
        case (fields.cls)
            CLS_I, CLS_LOAD, CLS_STORE: range_bad = !fits_simm(imm, 12);
            CLS_BRANCH:                 range_bad = !fits_simm(imm, 13) || imm[0];
            CLS_JAL:                    range_bad = !fits_simm(imm, 21) || imm[0];
            default:                    range_bad = 1'b0;
        endcase
`endif
    end

    assign enc_err = illegal || range_bad;

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder / program loader: two-stage pipeline writing packed words
// to sequential imem addresses. Optional immediate range errors via ENC_RANGE_CHECK_EN.
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              overflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              s1_valid_q, s1_valid_d;
    instr_fields_t     s1_q, s1_d;
    logic              s2_valid_q, s2_valid_d;
    logic [31:0]       s2_word_q, s2_word_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic [31:0]       packed_word;
    logic              pack_err;

    assign accept = in_valid && (state_q == ST_RUN);

    instr_field_pack u_pack (
        .fields  (s1_q),
        .word    (packed_word),
        .enc_err (pack_err)
    );

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        addr_d     = addr_q;
        err_d      = err_q;
        ovf_d      = ovf_q;

        s1_valid_d = accept;
        s1_d       = s1_q;
        if (accept) begin
            s1_d.cls      = instr_class_e'(in_class);
            s1_d.rd       = in_rd;
            s1_d.rs1      = in_rs1;
            s1_d.rs2      = in_rs2;
            s1_d.funct3   = in_funct3;
            s1_d.funct7b5 = in_funct7b5;
            s1_d.imm      = in_imm;
        end

        s2_valid_d = s1_valid_q;
        s2_word_d  = s2_word_q;
        if (s1_valid_q) begin
            s2_word_d = packed_word;
            if (pack_err) err_d = 1'b1;
        end

        if (s2_valid_q && (addr_q != '1)) addr_d = addr_q + ADDR_W'(1);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    beat_cnt_d = '0;
                    addr_d     = '0;
                    err_d      = 1'b0;
                    ovf_d      = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (in_last) state_d = ST_DRAIN;
                    // Last free slot consumed: stop accepting even without in_last.
                    if (beat_cnt_q == '1) begin
                        state_d = ST_DRAIN;
                        if (!in_last) ovf_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + ADDR_W'(1);
                    end
                end
            end
            // Stage 1 empty means the final word is in stage 2 now, so done
            // lands on the cycle right after that write.
            ST_DRAIN: if (!s1_valid_q) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            addr_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_word_q  <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            addr_q     <= addr_d;
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_word_q  <= s2_word_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready   = (state_q == ST_RUN);
    assign imem_we    = s2_valid_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = s2_word_q;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN) || s1_valid_q || s2_valid_q;
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings plus randomized sessions
// against an arithmetic reference model; second instance with ADDR_W=2 for overflow.
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, in_valid, in_funct7b5, in_last;
    logic        sm_start, sm_valid;
    logic [2:0]  in_class, in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;

    logic        in_ready, imem_we, busy, done, err, overflow;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;

    logic        sm_in_ready, sm_imem_we, sm_busy, sm_done, sm_err, sm_overflow;
    logic [1:0]  sm_imem_addr;
    logic [31:0] sm_imem_wdata;

    instr_encoder #(.ADDR_W(10)) u_dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .overflow(overflow)
    );

    instr_encoder #(.ADDR_W(2)) u_small (
        .clk(clk), .reset(reset), .start(sm_start), .in_valid(sm_valid), .in_ready(sm_in_ready),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm), .in_last(in_last),
        .imem_we(sm_imem_we), .imem_addr(sm_imem_addr), .imem_wdata(sm_imem_wdata),
        .busy(sm_busy), .done(sm_done), .err(sm_err), .overflow(sm_overflow)
    );

`ifdef ENC_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int          acc;
    } exp_t;

    exp_t mq[$];
    exp_t sq[$];
    exp_t me, se;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_wr = 0;
    int sm_wr_cnt = 0;
    int sess_cnt = 0;
    bit sess_err = 1'b0;

    int bnd_i[4] = '{-2048, 2047, 2048, -2049};
    int bnd_b[5] = '{-4096, 4094, 4095, 4096, -4098};
    int bnd_j[5] = '{-1048576, 1048574, 1048575, 1048578, -1048578};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference encoding built from the RV32I field layout with shifts and masks.
    function automatic logic [31:0] model_word(input int unsigned cls, input int unsigned rd,
                                               input int unsigned rs1, input int unsigned rs2,
                                               input int unsigned f3, input int unsigned f7b5,
                                               input int unsigned u);
        int unsigned regs;
        regs = (rs2 << 20) | (rs1 << 15) | (f3 << 12);
        case (cls)
            0: return (f7b5 << 30) | regs | (rd << 7) | 32'h33;
            1: return ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            2: return ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
            3: return (((u >> 5) & 32'h7F) << 25) | regs | ((u & 32'h1F) << 7) | 32'h23;
            4: return (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | regs
                      | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
            5: return (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                      | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
            default: return 32'h13;
        endcase
    endfunction

    function automatic bit model_err(input int cls, input int imm);
        bit odd;
        odd = (imm & 1) != 0;
        if (cls > 5) return 1'b1;
        if (!RANGE_CHK) return 1'b0;
        case (cls)
            1, 2, 3: return (imm < -2048) || (imm > 2047);
            4:       return (imm < -4096) || (imm > 4094) || odd;
            5:       return (imm < -1048576) || (imm > 1048574) || odd;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int rand_imm(input int cls);
        int r;
        int v;
        r = $urandom_range(0, 9);
        if (r < 6) begin
            v = int'($urandom_range(0, 4095)) - 2048;
            if (cls == 4 || cls == 5) v = v & ~1;
            return v;
        end
        if (r < 9) begin
            if (cls == 4) return bnd_b[$urandom_range(0, 4)];
            if (cls == 5) return bnd_j[$urandom_range(0, 4)];
            return bnd_i[$urandom_range(0, 3)];
        end
        return int'($urandom);
    endfunction

    always @(negedge clk) begin
        if (imem_we) begin
            if (mq.size() == 0) begin
                check_eq("spurious_we", 32'(imem_we), 32'd0);
            end else begin
                me = mq.pop_front();
                check_eq("addr", 32'(imem_addr), me.addr);
                check_eq("word", imem_wdata, me.word);
                check_eq("lat", cyc - me.acc, 32'd1);
            end
            last_wr = cyc;
        end
        if (sm_imem_we) begin
            sm_wr_cnt++;
            if (sq.size() == 0) begin
                check_eq("sm_spurious_we", 32'(sm_imem_we), 32'd0);
            end else begin
                se = sq.pop_front();
                check_eq("sm_addr", 32'(sm_imem_addr), se.addr);
                check_eq("sm_word", sm_imem_wdata, se.word);
                check_eq("sm_lat", cyc - se.acc, 32'd1);
            end
        end
    end

    // All drive tasks begin and end just after a falling edge.
    task automatic start_session();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        sess_cnt = 0;
        sess_err = 1'b0;
    endtask

    task automatic send_beat(input int cls, input int rd, input int rs1, input int rs2,
                             input int f3, input int f7b5, input int imm, input bit last,
                             input logic [31:0] exp_word, input bit exp_err, input bit mid_start);
        int waited;
        in_class    = cls[2:0];
        in_rd       = rd[4:0];
        in_rs1      = rs1[4:0];
        in_rs2      = rs2[4:0];
        in_funct3   = f3[2:0];
        in_funct7b5 = f7b5[0];
        in_imm      = imm;
        in_last     = last;
        in_valid    = 1'b1;
        start       = mid_start;
        waited      = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_eq("ready", 32'(in_ready), 32'd1);
        if (in_ready) begin
            mq.push_back('{addr: sess_cnt, word: exp_word, acc: cyc + 1});
            sess_cnt++;
            sess_err |= exp_err;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_done(input bit exp_ovf);
        int n;
        n = 0;
        in_valid = 1'b0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq("done", 32'(done), 32'd1);
        check_eq("done_lat", cyc - last_wr, 32'd1);
        check_eq("err", 32'(err), 32'(sess_err));
        check_eq("overflow", 32'(overflow), 32'(exp_ovf));
        check_eq("busy_end", 32'(busy), 32'd0);
        check_eq("q_empty", mq.size(), 32'd0);
    endtask

    task automatic sm_wait_done();
        int n;
        n = 0;
        sm_valid = 1'b0;
        while (!sm_done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq("sm_done", 32'(sm_done), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        sm_start = 1'b0; sm_valid = 1'b0;
        in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7b5 = 1'b0; in_imm = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_flags", 32'({in_ready, imem_we, busy, done, err, overflow}), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'd0);
        check_eq("rst_wdata", imem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // addi x1, x0, 5
        start_session();
        check_eq("busy_run", 32'(busy), 32'd1);
        send_beat(1, 1, 0, 0, 0, 0, 5, 1'b1, 32'h0050_0093, 1'b0, 1'b0);
        wait_done(1'b0);

        // add x3,x1,x2 then sub x3,x1,x2 back to back
        start_session();
        send_beat(0, 3, 1, 2, 0, 0, 0, 1'b0, 32'h0020_81B3, 1'b0, 1'b0);
        send_beat(0, 3, 1, 2, 0, 1, 0, 1'b1, 32'h4020_81B3, 1'b0, 1'b0);
        wait_done(1'b0);

        // sw x2,8(x1); beq x1,x2,-4; jal x1,8
        start_session();
        send_beat(3, 0, 1, 2, 2, 0, 8,  1'b0, 32'h0020_A423, 1'b0, 1'b0);
        send_beat(4, 0, 1, 2, 0, 0, -4, 1'b0, 32'hFE20_8EE3, 1'b0, 1'b0);
        send_beat(5, 1, 0, 0, 0, 0, 8,  1'b1, 32'h0080_00EF, 1'b0, 1'b0);
        wait_done(1'b0);

        // Out-of-range I immediate and an illegal class
        start_session();
        send_beat(1, 1, 0, 0, 0, 0, 2048, 1'b0, 32'h8000_0093, RANGE_CHK, 1'b0);
        send_beat(6, 7, 3, 4, 5, 1, 99,   1'b1, 32'h0000_0013, 1'b1, 1'b0);
        wait_done(1'b0);

        for (int s = 0; s < 8; s++) begin
            int nb;
            nb = $urandom_range(1, 24);
            start_session();
            for (int b = 0; b < nb; b++) begin
                int cls, rd, rs1, rs2, f3, f7, imm, gap;
                cls = $urandom_range(0, 7);
                rd  = $urandom_range(0, 31);
                rs1 = $urandom_range(0, 31);
                rs2 = $urandom_range(0, 31);
                f3  = $urandom_range(0, 7);
                f7  = $urandom_range(0, 1);
                imm = rand_imm(cls);
                gap = $urandom_range(0, 2);
                repeat (gap) @(negedge clk);
                send_beat(cls, rd, rs1, rs2, f3, f7, imm, b == nb - 1,
                          model_word(cls, rd, rs1, rs2, f3, f7, imm), model_err(cls, imm),
                          (b == 2) && (nb > 3));
            end
            wait_done(1'b0);
        end

        // Small instance: five beats offered without last into a 4-word memory
        sm_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sm_start  = 1'b0;
        sm_wr_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            in_class = 3'd1; in_rd = 5'(i + 1); in_rs1 = 5'd0; in_funct3 = 3'd0;
            in_imm = i; in_last = 1'b0; sm_valid = 1'b1;
            check_eq("sm_ready", 32'(sm_in_ready), (i < 4) ? 32'd1 : 32'd0);
            if (sm_in_ready)
                sq.push_back('{addr: i, word: model_word(1, i + 1, 0, 0, 0, 0, i), acc: cyc + 1});
            @(posedge clk);
            @(negedge clk);
        end
        sm_wait_done();
        check_eq("sm_overflow", 32'(sm_overflow), 32'd1);
        check_eq("sm_err", 32'(sm_err), 32'd0);
        check_eq("sm_wr_cnt", sm_wr_cnt, 32'd4);
        check_eq("sm_addr_sat", 32'(sm_imem_addr), 32'd3);

        // A fresh session clears overflow and restarts at address 0
        sm_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sm_start = 1'b0;
        in_class = 3'd5; in_rd = 5'd1; in_imm = 8; in_last = 1'b1; sm_valid = 1'b1;
        sq.push_back('{addr: 0, word: model_word(5, 1, 0, 0, 0, 0, 8), acc: cyc + 1});
        @(posedge clk);
        @(negedge clk);
        in_last = 1'b0;
        sm_wait_done();
        check_eq("sm_ovf_clr", 32'(sm_overflow), 32'd0);

        // Reset the cycle after an accept: the in-flight beat must vanish
        start_session();
        send_beat(1, 2, 0, 0, 0, 0, 7, 1'b0, model_word(1, 2, 0, 0, 0, 0, 7), 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mq.delete();
        check_eq("mid_rst_flags", 32'({in_ready, imem_we, busy, done, err, overflow}), 32'd0);
        check_eq("mid_rst_addr", 32'(imem_addr), 32'd0);
        check_eq("mid_rst_wdata", imem_wdata, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("no_we_after_rst", 32'(imem_we), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder and program loader, the inverse of the control decoder: it accepts field-level instruction descriptions over a valid/ready handshake, packs them into 32-bit machine words, and writes them to sequential instruction-memory word addresses. It sits between the testbench or boot-loader front end and the instruction memory of the single-cycle core. The core is held in reset while the encoder runs.

## Interface
- ADDR_W, 10: instruction-memory word-address width; capacity is 2**ADDR_W words.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begins a load session at word address 0; honoured only in IDLE or DONE.
- in_valid  in  1  instruction beat valid.
- in_ready  out  1  encoder accepts the beat this cycle.
- in_class  in  3  0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5=JAL; 6 and 7 are illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3 field.
- in_funct7b5  in  1  instruction bit 30; used for R-type only.
- in_imm  in  32  signed immediate, unencoded byte offset.
- in_last  in  1  marks the final beat of the program.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  session active or pipeline non-empty.
- done  out  1  held high in DONE.
- err  out  1  sticky; set on any encode error in the session.
- overflow  out  1  sticky; memory filled before in_last.

## Operation
- States:
  - IDLE→RUN on start, which clears the address counter, err and overflow.
  - RUN→DRAIN on an accepted beat with in_last=1, or on acceptance of the 2**ADDR_W-th beat. In the second case overflow=1 unless in_last was also set.
  - DRAIN→DONE once the pipeline is empty.
  - DONE→RUN on start.
- in_ready = (state==RUN). A beat is accepted when in_valid && in_ready.
- Opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111.
- Field packing:
  - R: funct7 = {1'b0, funct7b5, 5'b0}.
  - I and LOAD: imm[11:0].
  - STORE: imm[11:5] and imm[4:0].
  - BRANCH: imm[12|10:5] and imm[4:1|11].
  - JAL: imm[20|10:1|11|19:12].
  - Unused register and funct fields are taken from the inputs verbatim. JAL ignores rs1, rs2 and funct3.
- An illegal class writes NOP 0x00000013 and sets err.
- The address counter increments after every write and saturates at the last address.
- start in RUN or DRAIN is ignored.

## Timing
- Two-stage pipeline:
  - Stage 1 registers the raw fields at acceptance.
  - Stage 2 registers the encoded word.
  - A beat accepted at edge N produces imem_we=1 during cycle N+2. imem_addr and imem_wdata are valid with it.
- Throughput is one word per cycle with no back-pressure from memory.
- done rises the cycle after the final imem_we.
- Reset values: in_ready, imem_we, busy, done, err and overflow are 0. imem_addr and imem_wdata are 0. State is IDLE and pipeline valids are cleared.
- Reset mid-session aborts immediately. Any beat in flight is discarded and no further write occurs.

## Configuration
- ENC_RANGE_CHECK_EN defined: err is also set when any of the following holds. The word is still written with truncated bits.
  - I, LOAD or STORE imm is outside [-2048, 2047].
  - BRANCH imm is outside [-4096, 4094] or imm[0]=1.
  - JAL imm is outside ±1 MiB or imm[0]=1.
- ENC_RANGE_CHECK_EN undefined: err is set only for an illegal class.

## Structure
- Package riscv_enc_pkg holds:
  - the class enum;
  - the opcode localparams;
  - the NOP constant.
- Combinational sub-module instr_field_pack (class + fields → word, plus range-error flag) sits between the two pipeline registers. FSM, counter and flags live in instr_encoder.

## Test plan
- start, then I-class rd=1 rs1=0 f3=0 imm=5 with last → imem_wdata=0x00500093 at addr 0, two cycles after accept; done one cycle later.
- Back-to-back R beats for add x3,x1,x2 then the same with funct7b5=1 → 0x002081B3 at addr 0 and 0x402081B3 at addr 1 on consecutive cycles.
- sw x2,8(x1) → 0x0020A423; beq x1,x2,-4 → 0xFE208EE3; jal x1,8 → 0x008000EF.
- ENC_RANGE_CHECK_EN defined, I-class imm=2048 → err=1, word 0x80000093 written. Class 6 → 0x00000013 written with err=1.
- ADDR_W=2, five beats offered without last → four accepted, in_ready low after the fourth, writes to addr 0..3, overflow=1, done=1.
- reset asserted the cycle after an accept → no imem_we follows; all outputs are 0 next cycle.
